// File: rtl/radarpim_stream_axi_writer.sv
// Stream-to-AXI write burster: packs a valid/ready sample stream into INCR bursts at
// consecutive SRAM addresses, one burst in flight, never crossing a 4 KB page.

module radarpim_stream_axi_writer #(
   parameter int unsigned BW_ADDR      = 32,
   parameter int unsigned BW_DATA      = 32,
   parameter int unsigned BW_AXI_TID   = 4,
   parameter int unsigned BW_NUM_WORDS = 16,
   parameter int unsigned MAX_BURST    = 16,
   parameter int unsigned AXI_ID       = 0
) (
   input  logic                    clk,
   input  logic                    rstnn,
   input  logic                    start,
   input  logic [BW_ADDR-1:0]      base_addr,
   input  logic [BW_NUM_WORDS-1:0] num_words,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   input  logic [BW_DATA-1:0]      s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [BW_AXI_TID-1:0]   txawid,
   output logic [BW_ADDR-1:0]      txawaddr,
   output logic [3:0]              txawlen,
   output logic [2:0]              txawsize,
   output logic [1:0]              txawburst,
   output logic                    txawvalid,
   input  logic                    txawready,
   output logic [BW_AXI_TID-1:0]   txwid,
   output logic [BW_DATA-1:0]      txwdata,
   output logic [3:0]              txwstrb,
   output logic                    txwlast,
   output logic                    txwvalid,
   input  logic                    txwready,
   input  logic [BW_AXI_TID-1:0]   txbid,
   input  logic [1:0]              txbresp,
   input  logic                    txbvalid,
   output logic                    txbready
);

   typedef enum logic [2:0] {StIdle, StCalc, StAw, StW, StB, StFin} state_e;

   state_e                  state_q;
   logic [BW_ADDR-1:0]      addr_q;
   logic [BW_NUM_WORDS-1:0] remaining_q;
   logic [3:0]              beat_q;
   logic [10:0]             room_words;
   logic [4:0]              burst_len;
   logic [4:0]              beat_len;
   logic                    in_w;
   logic                    unused_bid;

   // Words left before the next 4 KB page; addr_q is always word aligned.
   assign room_words = 11'h400 - {1'b0, addr_q[11:2]};

   always_comb begin
      if (32'(remaining_q) < MAX_BURST) burst_len = 5'(remaining_q);
      else                              burst_len = 5'(MAX_BURST);
      if (room_words < 11'(burst_len))  burst_len = room_words[4:0];
   end

   assign beat_len   = {1'b0, txawlen} + 5'd1;
   assign in_w       = (state_q == StW);
   assign s_ready    = in_w & txwready;
   assign txwvalid   = in_w & s_valid;
   assign txwdata    = in_w ? s_data : '0;
   assign txwlast    = in_w & (beat_q == txawlen);
   assign txawaddr   = addr_q;
   assign txawid     = BW_AXI_TID'(AXI_ID);
   assign txwid      = BW_AXI_TID'(AXI_ID);
   assign txawsize   = 3'b010;
   assign txawburst  = 2'b01;
   assign txwstrb    = 4'hF;
   assign unused_bid = ^txbid;

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         remaining_q <= '0;
         beat_q      <= '0;
         txawlen     <= '0;
         txawvalid   <= 1'b0;
         txbready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  addr_q      <= {base_addr[BW_ADDR-1:2], 2'b00};
                  remaining_q <= num_words;
                  error       <= 1'b0;
                  busy        <= 1'b1;
                  state_q     <= StCalc;
               end
            end
            StCalc: begin
               if (remaining_q == '0) begin
                  done    <= 1'b1;
                  state_q <= StFin;
               end else begin
                  txawlen   <= 4'(burst_len - 5'd1);
                  txawvalid <= 1'b1;
                  state_q   <= StAw;
               end
            end
            StAw: begin
               if (txawready) begin
                  txawvalid <= 1'b0;
                  beat_q    <= '0;
                  state_q   <= StW;
               end
            end
            StW: begin
               if (s_valid && txwready) begin
                  beat_q <= beat_q + 4'd1;
                  if (beat_q == txawlen) begin
                     txbready <= 1'b1;
                     state_q  <= StB;
                  end
               end
            end
            StB: begin
               if (txbvalid) begin
                  txbready    <= 1'b0;
                  error       <= error | (txbresp != 2'b00);
                  addr_q      <= addr_q + BW_ADDR'({beat_len, 2'b00});
                  remaining_q <= remaining_q - BW_NUM_WORDS'(beat_len);
                  state_q     <= StCalc;
               end
            end
            StFin: begin
               // busy stays up through the done cycle and falls with it
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_radarpim_stream_axi_writer.sv
// Directed bench for radarpim_stream_axi_writer: stream source, AXI slave with an SRAM
// model, per-scenario tasks with hand-computed burst tables.

module tb_radarpim_stream_axi_writer;

   logic        clk;
   logic        rstnn;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] num_words;
   logic        busy, done, error;
   logic [31:0] s_data;
   logic        s_valid, s_ready;
   logic [3:0]  txawid, txwid, txbid;
   logic [31:0] txawaddr, txwdata;
   logic [3:0]  txawlen, txwstrb;
   logic [2:0]  txawsize;
   logic [1:0]  txawburst, txbresp;
   logic        txawvalid, txawready, txwlast, txwvalid, txwready, txbvalid, txbready;

   radarpim_stream_axi_writer dut (
      .clk(clk), .rstnn(rstnn), .start(start), .base_addr(base_addr),
      .num_words(num_words), .busy(busy), .done(done), .error(error),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .txawid(txawid), .txawaddr(txawaddr), .txawlen(txawlen), .txawsize(txawsize),
      .txawburst(txawburst), .txawvalid(txawvalid), .txawready(txawready),
      .txwid(txwid), .txwdata(txwdata), .txwstrb(txwstrb), .txwlast(txwlast),
      .txwvalid(txwvalid), .txwready(txwready), .txbid(txbid), .txbresp(txbresp),
      .txbvalid(txbvalid), .txbready(txbready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int asserts, fails;
   int cyc;

   // stimulus owned by the main thread
   logic [31:0] src_mem [0:63];
   int          src_n, job_seq;
   logic        gap_en, bp_en;
   logic [1:0]  bresp_tab [0:63];

   // owned by the driver thread
   int src_rd, seen_seq, b_issued;

   // owned by the monitor thread
   bit          fire_s, fire_b, aw_open;
   int          b_req, done_cnt, done_cyc, busy_cnt, awv_cnt, order_err;
   logic        done_err;
   logic [31:0] waddr;
   logic [31:0] aw_addr_log [$];
   logic [3:0]  aw_len_log [$];
   logic        w_last_log [$];
   logic [31:0] sram [logic [31:0]];

   // snapshots taken by run_job
   int aw0, w0, done0, busy0, awv0, ord0, st_cyc;

   assign txbid = 4'h5;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor samples mid-cycle; each handshake it sees completes on the next rising edge.
   initial begin
      fire_s = 0; fire_b = 0; aw_open = 0; b_req = 0; done_cnt = 0; done_cyc = 0;
      busy_cnt = 0; awv_cnt = 0; order_err = 0; done_err = 0; waddr = '0;
      forever begin
         @(negedge clk);
         if (!rstnn) aw_open = 0;
         fire_s = s_valid && s_ready;
         fire_b = txbvalid && txbready;
         if (txwvalid && !aw_open) order_err++;
         if (txawvalid && txawready) begin
            aw_addr_log.push_back(txawaddr);
            aw_len_log.push_back(txawlen);
            waddr   = txawaddr;
            aw_open = 1;
         end
         if (txwvalid && txwready) begin
            sram[waddr] = txwdata;
            waddr += 32'd4;
            w_last_log.push_back(txwlast);
            if (txwlast) begin
               aw_open = 0;
               b_req++;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = error;
         end
         if (busy) busy_cnt++;
         if (txawvalid) awv_cnt++;
      end
   end

   // Stream source and AXI slave responder.
   initial begin
      s_valid = 0; s_data = '0; txawready = 0; txwready = 0; txbvalid = 0; txbresp = '0;
      src_rd = 0; seen_seq = 0; b_issued = 0;
      forever begin
         @(posedge clk);
         #1;
         if (job_seq != seen_seq) begin
            seen_seq = job_seq;
            src_rd   = 0;
         end else if (fire_s) begin
            src_rd++;
         end
         s_valid   = (src_rd < src_n) && (!gap_en || $urandom_range(0, 2) != 0);
         s_data    = (src_rd < src_n) ? src_mem[src_rd] : 32'h0;
         txawready = !bp_en || $urandom_range(0, 1) == 1;
         txwready  = !bp_en || $urandom_range(0, 2) != 0;
         if (fire_b) begin
            txbvalid = 0;
         end else if (!txbvalid && b_req > b_issued) begin
            txbresp  = bresp_tab[b_issued];
            b_issued++;
            txbvalid = 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input logic [31:0] base, input int n, input logic [7:0] tag,
                          input int budget);
      int k;
      tick();
      for (int i = 0; i < n; i++) src_mem[i] = {tag, 24'(i * 7 + 1)};
      src_n = n;
      job_seq++;
      aw0 = aw_addr_log.size(); w0 = w_last_log.size(); done0 = done_cnt;
      busy0 = busy_cnt; awv0 = awv_cnt; ord0 = order_err;
      tick();
      base_addr = base;
      num_words = 16'(n);
      start     = 1;
      st_cyc    = cyc;
      tick();
      start = 0;
      if (budget > 0) begin
         k = 0;
         while (done_cnt == done0 && k < budget) begin
            tick();
            k++;
         end
         asserts++;
         if (done_cnt == done0) begin
            fails++;
            $display("FAIL job_timeout: got no done after %0d cycles expected done", budget);
         end
         repeat (3) tick();
      end
   endtask

   task automatic test_reset();
      rstnn = 0;
      repeat (3) tick();
      asserts++;
      if ({busy, done, error, txawvalid, txwvalid, txwlast, s_ready, txbready} !== 8'h0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {busy, done, error, txawvalid, txwvalid, txwlast, s_ready, txbready});
      end
      asserts++;
      if ({txawaddr, txawlen, txwdata} !== 68'h0) begin
         fails++;
         $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", txawaddr, txawlen, txwdata);
      end
      rstnn = 1;
      repeat (2) tick();
      asserts++;
      if ({busy, txawvalid, s_ready} !== 3'b000) begin
         fails++;
         $display("FAIL idle_after_reset: got %b expected 000", {busy, txawvalid, s_ready});
      end
   endtask

   task automatic test_burst_split();
      logic [31:0] exp_addr [3];
      logic [3:0]  exp_len  [3];
      logic [31:0] got;
      exp_addr = '{32'h0, 32'h40, 32'h80};
      exp_len  = '{4'd15, 4'd15, 4'd7};
      run_job(32'h0, 40, 8'hA1, 300);
      asserts++;
      if (aw_addr_log.size() - aw0 != 3) begin
         fails++;
         $display("FAIL split_aw_count: got %0d expected 3", aw_addr_log.size() - aw0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            asserts++;
            if (aw_addr_log[aw0+i] !== exp_addr[i] || aw_len_log[aw0+i] !== exp_len[i]) begin
               fails++;
               $display("FAIL split_aw[%0d]: got %h/%0d expected %h/%0d", i,
                        aw_addr_log[aw0+i], aw_len_log[aw0+i], exp_addr[i], exp_len[i]);
            end
         end
      end
      asserts++;
      if (w_last_log.size() - w0 != 40) begin
         fails++;
         $display("FAIL split_beats: got %0d expected 40", w_last_log.size() - w0);
      end else begin
         for (int i = 0; i < 40; i++) begin
            asserts++;
            if (w_last_log[w0+i] !== (i == 15 || i == 31 || i == 39)) begin
               fails++;
               $display("FAIL split_wlast[%0d]: got %b", i, w_last_log[w0+i]);
            end
         end
      end
      for (int i = 0; i < 40; i++) begin
         got = sram.exists(32'(i * 4)) ? sram[32'(i * 4)] : 32'hxxxxxxxx;
         asserts++;
         if (got !== {8'hA1, 24'(i * 7 + 1)}) begin
            fails++;
            $display("FAIL split_data[%0d]: got %h expected %h", i, got, {8'hA1, 24'(i * 7 + 1)});
         end
      end
      asserts++;
      if (done_cnt - done0 != 1 || done_err !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL split_done: got done=%0d err=%b busy=%b expected 1/0/0",
                  done_cnt - done0, done_err, busy);
      end
      asserts++;
      if ({txawsize, txawburst, txwstrb, txawid, txwid} !== {3'b010, 2'b01, 4'hF, 4'h0, 4'h0})
      begin
         fails++;
         $display("FAIL axi_consts: got %b expected 010_01_1111_0000_0000",
                  {txawsize, txawburst, txwstrb, txawid, txwid});
      end
   endtask

   task automatic test_4k_boundary();
      logic [31:0] got;
      run_job(32'hFF8, 5, 8'hB2, 100);
      asserts++;
      if (aw_addr_log.size() - aw0 != 2) begin
         fails++;
         $display("FAIL 4k_aw_count: got %0d expected 2", aw_addr_log.size() - aw0);
      end else begin
         asserts++;
         if (aw_addr_log[aw0] !== 32'hFF8 || aw_len_log[aw0] !== 4'd1) begin
            fails++;
            $display("FAIL 4k_aw0: got %h/%0d expected ff8/1", aw_addr_log[aw0], aw_len_log[aw0]);
         end
         asserts++;
         if (aw_addr_log[aw0+1] !== 32'h1000 || aw_len_log[aw0+1] !== 4'd2) begin
            fails++;
            $display("FAIL 4k_aw1: got %h/%0d expected 1000/2",
                     aw_addr_log[aw0+1], aw_len_log[aw0+1]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         got = sram.exists(32'hFF8 + 32'(i * 4)) ? sram[32'hFF8 + 32'(i * 4)] : 32'hxxxxxxxx;
         asserts++;
         if (got !== {8'hB2, 24'(i * 7 + 1)}) begin
            fails++;
            $display("FAIL 4k_data[%0d]: got %h expected %h", i, got, {8'hB2, 24'(i * 7 + 1)});
         end
      end
   endtask

   task automatic test_zero_words();
      run_job(32'h500, 0, 8'hC3, 20);
      asserts++;
      if (done_cnt - done0 != 1 || done_cyc - st_cyc != 2) begin
         fails++;
         $display("FAIL zero_done: got count=%0d delay=%0d expected 1/2",
                  done_cnt - done0, done_cyc - st_cyc);
      end
      asserts++;
      if (busy_cnt - busy0 != 2) begin
         fails++;
         $display("FAIL zero_busy: got %0d cycles expected 2", busy_cnt - busy0);
      end
      asserts++;
      if (awv_cnt - awv0 != 0) begin
         fails++;
         $display("FAIL zero_awvalid: got %0d cycles expected 0", awv_cnt - awv0);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got;
      gap_en = 1;
      bp_en  = 1;
      run_job(32'h100, 17, 8'hD4, 600);
      gap_en = 0;
      bp_en  = 0;
      asserts++;
      if (aw_addr_log.size() - aw0 != 2) begin
         fails++;
         $display("FAIL bp_aw_count: got %0d expected 2", aw_addr_log.size() - aw0);
      end else begin
         asserts++;
         if ({aw_addr_log[aw0], aw_len_log[aw0], aw_addr_log[aw0+1], aw_len_log[aw0+1]}
             !== {32'h100, 4'd15, 32'h140, 4'd0}) begin
            fails++;
            $display("FAIL bp_aw: got %h/%0d %h/%0d expected 100/15 140/0", aw_addr_log[aw0],
                     aw_len_log[aw0], aw_addr_log[aw0+1], aw_len_log[aw0+1]);
         end
      end
      asserts++;
      if (w_last_log.size() - w0 != 17) begin
         fails++;
         $display("FAIL bp_beats: got %0d expected 17", w_last_log.size() - w0);
      end
      for (int i = 0; i < 17; i++) begin
         got = sram.exists(32'h100 + 32'(i * 4)) ? sram[32'h100 + 32'(i * 4)] : 32'hxxxxxxxx;
         asserts++;
         if (got !== {8'hD4, 24'(i * 7 + 1)}) begin
            fails++;
            $display("FAIL bp_data[%0d]: got %h expected %h", i, got, {8'hD4, 24'(i * 7 + 1)});
         end
      end
      asserts++;
      if (order_err - ord0 != 0) begin
         fails++;
         $display("FAIL bp_w_before_aw: got %0d expected 0", order_err - ord0);
      end
   endtask

   task automatic test_error();
      bresp_tab[b_issued + 1] = 2'b10;
      run_job(32'h2000, 40, 8'hE5, 300);
      asserts++;
      if (done_err !== 1'b1) begin
         fails++;
         $display("FAIL err_at_done: got %b expected 1", done_err);
      end
      repeat (5) tick();
      asserts++;
      if (error !== 1'b1) begin
         fails++;
         $display("FAIL err_sticky: got %b expected 1", error);
      end
      run_job(32'h800, 3, 8'hE6, 100);
      asserts++;
      if (done_err !== 1'b0 || error !== 1'b0) begin
         fails++;
         $display("FAIL err_cleared: got %b/%b expected 0/0", done_err, error);
      end
   endtask

   task automatic test_reset_mid_burst();
      int          k;
      logic [31:0] got;
      run_job(32'h0, 16, 8'hF7, 0);
      k = 0;
      while (w_last_log.size() < w0 + 5 && k < 100) begin
         tick();
         k++;
      end
      asserts++;
      if (w_last_log.size() < w0 + 5) begin
         fails++;
         $display("FAIL rst_mid_progress: got %0d beats expected 5", w_last_log.size() - w0);
      end
      #2 rstnn = 0;
      #1;
      asserts++;
      if ({busy, done, error, txawvalid, txwvalid, txwlast, s_ready, txbready} !== 8'h0
          || txwdata !== 32'h0 || txawaddr !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid_outputs: got %b %h %h expected 0",
                  {busy, done, error, txawvalid, txwvalid, txwlast, s_ready, txbready},
                  txwdata, txawaddr);
      end
      repeat (3) tick();
      rstnn = 1;
      repeat (2) tick();
      asserts++;
      if (done_cnt != done0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_no_done: got done=%0d busy=%b expected 0/0",
                  done_cnt - done0, busy);
      end
      run_job(32'h300, 4, 8'hF8, 100);
      asserts++;
      if (aw_addr_log.size() - aw0 != 1 || aw_addr_log[aw0] !== 32'h300
          || aw_len_log[aw0] !== 4'd3) begin
         fails++;
         $display("FAIL rst_restart_aw: got %0d bursts expected one 300/3",
                  aw_addr_log.size() - aw0);
      end
      for (int i = 0; i < 4; i++) begin
         got = sram.exists(32'h300 + 32'(i * 4)) ? sram[32'h300 + 32'(i * 4)] : 32'hxxxxxxxx;
         asserts++;
         if (got !== {8'hF8, 24'(i * 7 + 1)}) begin
            fails++;
            $display("FAIL rst_restart_data[%0d]: got %h expected %h", i, got,
                     {8'hF8, 24'(i * 7 + 1)});
         end
      end
   endtask

   initial begin
      asserts = 0; fails = 0;
      rstnn = 0; start = 0; base_addr = '0; num_words = '0;
      gap_en = 0; bp_en = 0; src_n = 0; job_seq = 0;
      for (int i = 0; i < 64; i++) begin
         bresp_tab[i] = 2'b00;
         src_mem[i]   = '0;
      end
      test_reset();
      test_burst_split();
      test_4k_boundary();
      test_zero_words();
      test_backpressure();
      test_error();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/radarpim_stream_axi_writer.md
Name: radarpim_stream_axi_writer

Overview:
- Upstream feeder of the RadarPIM SRAM slave port.
- Accepts a valid/ready stream of 32-bit radar samples and writes them to consecutive SRAM addresses as AXI INCR write bursts.
- One burst outstanding at a time; completion and error are reported to the PIM control FSM.

Parameters:
BW_ADDR, 32, AXI address width
BW_DATA, 32, data width; only 32 supported (4-byte beats)
BW_AXI_TID, 4, AXI ID width
BW_NUM_WORDS, 16, width of the transfer length in words
MAX_BURST, 16, maximum beats per burst (1..16)
AXI_ID, 0, constant ID driven on txawid/txwid

Ports:
clk  in  1  clock
rstnn  in  1  reset
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  BW_ADDR  start byte address; bits [1:0] ignored (forced 0)
num_words  in  BW_NUM_WORDS  words to write
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on completion
error  out  1  sticky: some BRESP != OKAY in current job; cleared on next start
s_data  in  BW_DATA  sample
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid & s_ready
txawid/txawaddr/txawlen(4)/txawsize(3)/txawburst(2)/txawvalid  out  -  AW channel
txawready  in  1  AW ready
txwid/txwdata/txwstrb(4)/txwlast/txwvalid  out  -  W channel
txwready  in  1  W ready
txbid(BW_AXI_TID)/txbresp(2)/txbvalid  in  -  B channel
txbready  out  1  B ready

Behaviour:
- Single clock, clk; reset rstnn asynchronous, active-low. On reset all outputs 0, FSM in IDLE, counters cleared. Reset mid-job abandons the job silently; no done pulse.
- Constants: txawsize=3'b010, txawburst=2'b01 (INCR), txwstrb=4'hF, txawid=txwid=AXI_ID.
- FSM states: IDLE, CALC, AW, W, B, FIN.
- IDLE: start=1 -> latch addr={base_addr[BW_ADDR-1:2],2'b00}, remaining=num_words, clear error, busy=1; go CALC. start while busy is ignored.
- CALC (1 cycle): if remaining==0 go FIN. Else compute len = min(remaining, MAX_BURST, (4096-addr[11:0])>>2). Bursts never cross a 4 KB boundary. Go AW.
- AW: txawvalid=1, txawaddr=addr, txawlen=len-1. Hold stable until txawready. Then go W with beat counter=0.
- W: txwvalid=s_valid, txwdata=s_data, s_ready=txwready (combinational pass-through, zero added latency). A beat transfers when s_valid & txwready. txwlast=1 when beat counter==len-1. After the last beat transfers go B. s_ready=0 in all other states.
- B: txbready=1. On txbvalid: if txbresp!=2'b00 set error. addr+=len*4, remaining-=len; go CALC.
- FIN: done=1 for exactly one cycle, busy drops the same cycle; go IDLE.
- num_words=0: IDLE->CALC->FIN; done 2 cycles after start; no AXI traffic.
- Address arithmetic wraps modulo 2^BW_ADDR. txbid is ignored.
- AW-before-W ordering is strict: no W beat is presented before its AW handshake.
- Stream stalls (s_valid low) mid-burst hold txwvalid low. The burst is never closed early.

Test Plan:
- base_addr=0x0, num_words=40, stream always valid, slave always ready -> bursts AWADDR 0x0/0x40/0x80 with AWLEN 15/15/7; 40 W beats, txwlast on beats 16/32/40; done pulse once; error=0.
- base_addr=0xFF8, num_words=5 -> bursts AWADDR 0xFF8 AWLEN 1, then AWADDR 0x1000 AWLEN 2 (4 KB split).
- num_words=0 -> no txawvalid ever; done pulses exactly 2 cycles after start; busy high for 2 cycles.
- Random s_valid gaps and txwready/txawready back-pressure, num_words=17 -> data written equals stream order. Bench SRAM model read-back matches; no beat lost or duplicated.
- Second burst returns BRESP=2'b10 -> error=1 at done and stays until next start; next job with OKAY responses ends with error=0.
- Assert rstnn low mid-W of a 16-beat burst -> all outputs 0 immediately; no done. A new start after reset completes normally.
